// File: rtl/sbqm_pkg.sv
// Shared definitions for the single-bank queue manager: sizing constants,
// dispatch state encoding and small combinational helpers.
package sbqm_pkg;

   localparam int N_TELLERS   = 3;
   localparam int Q_MAX       = 7;
   localparam int SVC_TIME    = 3;
   localparam int ACK_TIMEOUT = 8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } dispState_t;

   // Number of set bits in a 3-bit vector (0..3).
   function automatic logic [1:0] popcount3(input logic [2:0] v);
      popcount3 = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

   // Round-robin pointer that follows a one-hot teller index (g+1 mod 3).
   function automatic logic [1:0] nextPtr(input logic [2:0] oneHot);
      case (oneHot)
         3'b001:  nextPtr = 2'd1;
         3'b010:  nextPtr = 2'd2;
         3'b100:  nextPtr = 2'd0;
         default: nextPtr = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: grants the first requester at or after ptr.
// Purely combinational; an out-of-range ptr behaves like ptr 0.
module rr_arbiter3 (
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic [2:0] gnt
);

   // Priority scan starting at the pointer position, wrapping around.
   always_comb begin
      gnt = 3'b000;
      case (ptr)
         2'd1: begin
            if (req[1])      gnt = 3'b010;
            else if (req[2]) gnt = 3'b100;
            else if (req[0]) gnt = 3'b001;
            else             gnt = 3'b000;
         end
         2'd2: begin
            if (req[2])      gnt = 3'b100;
            else if (req[0]) gnt = 3'b001;
            else if (req[1]) gnt = 3'b010;
            else             gnt = 3'b000;
         end
         default: begin
            if (req[0])      gnt = 3'b001;
            else if (req[1]) gnt = 3'b010;
            else if (req[2]) gnt = 3'b100;
            else             gnt = 3'b000;
         end
      endcase
   end

endmodule

// File: rtl/teller_dispatcher.sv
// Bank queue dispatcher: counts arrivals, owns the queue occupancy, offers the
// head-of-queue customer to an idle enabled teller round-robin, tracks teller
// busy state and publishes the wait estimate and full/empty/overflow flags.
module teller_dispatcher
   import sbqm_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       arrive,
   input  logic [2:0] teller_en,
   input  logic [2:0] teller_done,
   input  logic [2:0] teller_ack,
   output logic [2:0] grant,
   output logic [2:0] busy,
   output logic [2:0] q_count,
   output logic [4:0] wait_time,
   output logic       empty_flag,
   output logic       full_flag,
   output logic       overflow
);

   logic       arriveMeta_r, arriveSync_r, arrivePrev_r;
   logic       arrival_s;
   dispState_t state_r, stateNext_s;
   logic [2:0] grant_r, grantNext_s;
   logic [1:0] ptr_r, ptrNext_s;
   logic [3:0] timer_r, timerNext_s;
   logic [2:0] busy_r, busyNext_s;
   logic       dispatch_s;
   logic [2:0] eligible_s, arbGnt_s;
   logic [2:0] qCount_r, qNext_s;
   logic       overflow_r, overflowNext_s;
   logic       empty_r, full_r;
   logic [1:0] tellerCnt_s;
   logic [4:0] numer_s;
   logic [4:0] wait_r, waitNext_s;

   // Entry sensor: two-flop synchroniser plus one stage for falling-edge detect.
   always_ff @(posedge clk) begin
      if (reset) begin
         arriveMeta_r <= 1'b0;
         arriveSync_r <= 1'b0;
         arrivePrev_r <= 1'b0;
      end else begin
         arriveMeta_r <= arrive;
         arriveSync_r <= arriveMeta_r;
         arrivePrev_r <= arriveSync_r;
      end
   end

   assign arrival_s  = arrivePrev_r & ~arriveSync_r;
   assign eligible_s = teller_en & ~busy_r;

   rr_arbiter3 uArb (
      .req (eligible_s),
      .ptr (ptr_r),
      .gnt (arbGnt_s)
   );

   // Dispatch FSM: open an offer from IDLE, resolve it by ack, timeout or disable.
   always_comb begin
      stateNext_s = state_r;
      grantNext_s = grant_r;
      ptrNext_s   = ptr_r;
      timerNext_s = timer_r;
      dispatch_s  = 1'b0;
      busyNext_s  = busy_r & ~teller_done;
      case (state_r)
         IDLE: begin
            timerNext_s = 4'd0;
            if ((qCount_r != 3'd0) && (arbGnt_s != 3'b000)) begin
               grantNext_s = arbGnt_s;
               stateNext_s = OFFER;
            end else begin
               grantNext_s = 3'b000;
            end
         end
         OFFER: begin
            if ((teller_ack & grant_r) != 3'b000) begin
               // Ack overrides a same-cycle done for the same teller.
               busyNext_s  = busyNext_s | grant_r;
               dispatch_s  = 1'b1;
               ptrNext_s   = nextPtr(grant_r);
               grantNext_s = 3'b000;
               stateNext_s = IDLE;
            end else if ((timer_r == 4'(ACK_TIMEOUT - 1)) || ((teller_en & grant_r) == 3'b000)) begin
               ptrNext_s   = nextPtr(grant_r);
               grantNext_s = 3'b000;
               stateNext_s = IDLE;
            end else begin
               timerNext_s = timer_r + 4'd1;
            end
         end
         default: begin
            grantNext_s = 3'b000;
            stateNext_s = IDLE;
         end
      endcase
   end

   // FSM, offer timer, round-robin pointer and teller busy registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         grant_r <= 3'b000;
         ptr_r   <= 2'd0;
         timer_r <= 4'd0;
         busy_r  <= 3'b000;
      end else begin
         state_r <= stateNext_s;
         grant_r <= grantNext_s;
         ptr_r   <= ptrNext_s;
         timer_r <= timerNext_s;
         busy_r  <= busyNext_s;
      end
   end

   // Net queue update from one arrival and one accepted dispatch per cycle.
   always_comb begin
      qNext_s        = qCount_r;
      overflowNext_s = overflow_r;
      if (arrival_s && !dispatch_s) begin
         if (qCount_r == 3'(Q_MAX)) begin
            overflowNext_s = 1'b1;
         end else begin
            qNext_s = qCount_r + 3'd1;
         end
      end else if (!arrival_s && dispatch_s) begin
         if (qCount_r != 3'd0) begin
            qNext_s = qCount_r - 3'd1;
         end else begin
            qNext_s = qCount_r;
         end
      end else begin
         qNext_s = qCount_r;
      end
   end

   // Queue count and flags, flags derived from the next count so they line up.
   always_ff @(posedge clk) begin
      if (reset) begin
         qCount_r   <= 3'd0;
         overflow_r <= 1'b0;
         empty_r    <= 1'b1;
         full_r     <= 1'b0;
      end else begin
         qCount_r   <= qNext_s;
         overflow_r <= overflowNext_s;
         empty_r    <= (qNext_s == 3'd0);
         full_r     <= (qNext_s == 3'(Q_MAX));
      end
   end

   // Wait estimate: ceil-like share of the queue per staffed teller, 31 if none.
   always_comb begin
      tellerCnt_s = popcount3(teller_en);
      numer_s     = 5'(SVC_TIME) * (5'(qCount_r) + 5'(tellerCnt_s) - 5'd1);
      case (tellerCnt_s)
         2'd1:    waitNext_s = numer_s;
         2'd2:    waitNext_s = numer_s >> 1;
         2'd3:    waitNext_s = numer_s / 5'd3;
         default: waitNext_s = 5'd31;
      endcase
   end

   // Registered wait estimate, one cycle behind count/enable changes.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_r <= 5'd0;
      end else begin
         wait_r <= waitNext_s;
      end
   end

   assign grant      = grant_r;
   assign busy       = busy_r;
   assign q_count    = qCount_r;
   assign wait_time  = wait_r;
   assign empty_flag = empty_r;
   assign full_flag  = full_r;
   assign overflow   = overflow_r;

endmodule
